// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port
// between the fetch (inst) and MEM-stage (data) requesters.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_ok,
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   input  logic [3:0]        data_wen,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_ok,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wen,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wen_q, wen_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] irdata_q, irdata_d;
   logic [DATA_W-1:0] drdata_q, drdata_d;
   logic              win;
   logic [DATA_W-1:0] cap;

   // Outputs decode only from registers; no input reaches an output.
   assign mem_req    = (state_q == S_ADDR);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wen    = wen_q;
   assign inst_ok    = (state_q == S_RESP) & ~owner_q;
   assign data_ok    = (state_q == S_RESP) & owner_q;
   assign bus_err    = (state_q == S_RESP) & err_q;
   assign inst_rdata = irdata_q;
   assign data_rdata = drdata_q;

   // Next-state, grant, payload latch, wait timer and data capture.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wen_d    = wen_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      win      = 1'b0;
      cap      = mem_rvalid ? mem_rdata : '0;
      unique case (state_q)
         S_IDLE: begin
            if (inst_req || data_req) begin
               // data wins alone, or on a tie when inst went last
               win     = data_req & (~inst_req | ~last_q);
               owner_d = win;
               addr_d  = win ? data_addr : inst_addr;
               wdata_d = win ? data_wdata : '0;
               wen_d   = win ? data_wen : 4'b0000;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (mem_gnt) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_WAIT: begin
            if (mem_rvalid || cnt_q == TO_LAST) begin
               state_d = S_RESP;
               err_d   = ~mem_rvalid;
               if (owner_q) drdata_d = cap;
               else         irdata_d = cap;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wen_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wen_q    <= wen_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue scoreboard
// checked by an independent completion monitor.
module tb_mem_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic [31:0] inst_rdata;
   logic        inst_ok;
   logic        data_req = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_wen = '0;
   logic [31:0] data_rdata;
   logic        data_ok;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wen;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        bus_err;

   typedef struct {
      bit          own;
      logic [31:0] rd;
      bit          chk_rd;
      bit          err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ok_count = 0;

   mem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .inst_req  (inst_req),
      .inst_addr (inst_addr),
      .inst_rdata(inst_rdata),
      .inst_ok   (inst_ok),
      .data_req  (data_req),
      .data_addr (data_addr),
      .data_wdata(data_wdata),
      .data_wen  (data_wen),
      .data_rdata(data_rdata),
      .data_ok   (data_ok),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input bit own, input logic [31:0] rd,
                           input bit cr, input bit err);
      exp_t x;
      x.own = own;
      x.rd = rd;
      x.chk_rd = cr;
      x.err = err;
      sb.push_back(x);
   endtask

   // Memory side: wait for ADDR, check payload each ADDR cycle,
   // grant after gdly stall cycles, optionally answer next cycle.
   task automatic do_mem(input logic [31:0] ea, input logic [31:0] ew,
                         input logic [3:0] en, input int gdly,
                         input bit resp, input logic [31:0] rd,
                         output int gcyc);
      int n;
      n = 0;
      gcyc = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!mem_req) begin
         total++;
         bad++;
         $display("FAIL mem_req_wait: got 0 want 1");
         return;
      end
      for (int k = 0; k <= gdly; k++) begin
         chk("addr_req", 32'(mem_req), 32'd1);
         chk("addr_a", mem_addr, ea);
         chk("addr_wd", mem_wdata, ew);
         chk("addr_wen", 32'(mem_wen), 32'(en));
         if (k == gdly) mem_gnt = 1'b1;
         else @(negedge clk);
      end
      gcyc = cyc;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("wait_req", 32'(mem_req), 32'd0);
      if (resp) begin
         mem_rvalid = 1'b1;
         mem_rdata = rd;
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata = '0;
      end
   endtask

   task automatic wait_ok(output int t);
      int n;
      n = 0;
      while (!(inst_ok || data_ok) && n < 300) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      if (!(inst_ok || data_ok)) begin
         total++;
         bad++;
         $display("FAIL ok_wait: got 0 want 1");
      end
   endtask

   // Completion monitor: pops one expectation per ok pulse.
   always @(negedge clk) begin
      if (rst && (inst_ok || data_ok)) begin
         ok_count++;
         chk("ok_onehot", 32'(inst_ok & data_ok), 32'd0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: ok=1 want none");
         end else begin
            e = sb.pop_front();
            chk("owner", 32'(data_ok), 32'(e.own));
            if (e.chk_rd)
               chk("rdata", e.own ? data_rdata : inst_rdata, e.rd);
            chk("bus_err", 32'(bus_err), 32'(e.err));
         end
      end
   end

   initial begin
      int t;
      int g;
      int rc;
      int okc;

      repeat (2) @(negedge clk);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wd", mem_wdata, 32'd0);
      chk("rst_wen", 32'(mem_wen), 32'd0);
      chk("rst_iok", 32'(inst_ok), 32'd0);
      chk("rst_dok", 32'(data_ok), 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      chk("rst_ird", inst_rdata, 32'd0);
      chk("rst_drd", data_rdata, 32'd0);
      rst = 1'b1;

      // Simultaneous requests held: data, inst, data, inst.
      @(negedge clk);
      inst_addr = 32'h100;
      data_addr = 32'h200;
      data_wdata = 32'h11111111;
      data_wen = 4'b0000;
      inst_req = 1'b1;
      data_req = 1'b1;
      push_exp(1'b1, 32'hD0000001, 1'b1, 1'b0);
      push_exp(1'b0, 32'h10000001, 1'b1, 1'b0);
      push_exp(1'b1, 32'hD0000002, 1'b1, 1'b0);
      push_exp(1'b0, 32'h10000002, 1'b1, 1'b0);
      do_mem(32'h200, 32'h11111111, 4'h0, 0, 1'b1, 32'hD0000001, g);
      wait_ok(t);
      do_mem(32'h100, 32'h0, 4'h0, 0, 1'b1, 32'h10000001, g);
      wait_ok(t);
      do_mem(32'h200, 32'h11111111, 4'h0, 0, 1'b1, 32'hD0000002, g);
      wait_ok(t);
      do_mem(32'h100, 32'h0, 4'h0, 0, 1'b1, 32'h10000002, g);
      wait_ok(t);
      inst_req = 1'b0;
      data_req = 1'b0;

      // Single inst read at minimum latency.
      @(negedge clk);
      inst_addr = 32'hBFC00000;
      inst_req = 1'b1;
      rc = cyc;
      push_exp(1'b0, 32'h24080001, 1'b1, 1'b0);
      do_mem(32'hBFC00000, 32'h0, 4'h0, 0, 1'b1, 32'h24080001, g);
      wait_ok(t);
      inst_req = 1'b0;
      chk("inst_lat", 32'(t - rc), 32'd3);
      chk("drd_hold", data_rdata, 32'hD0000002);

      // Byte-enabled write with a 4-cycle grant stall.
      @(negedge clk);
      data_addr = 32'h10;
      data_wdata = 32'hDEADBEEF;
      data_wen = 4'b0011;
      data_req = 1'b1;
      push_exp(1'b1, 32'h0, 1'b0, 1'b0);
      do_mem(32'h10, 32'hDEADBEEF, 4'b0011, 4, 1'b1, 32'h5A5A5A5A, g);
      wait_ok(t);
      data_req = 1'b0;
      chk("ird_hold", inst_rdata, 32'h24080001);

      // Read with no response: times out after TO wait cycles.
      @(negedge clk);
      data_addr = 32'h80;
      data_wdata = 32'h0;
      data_wen = 4'b0000;
      data_req = 1'b1;
      push_exp(1'b1, 32'h0, 1'b1, 1'b1);
      do_mem(32'h80, 32'h0, 4'h0, 0, 1'b0, 32'h0, g);
      wait_ok(t);
      data_req = 1'b0;
      chk("to_lat", 32'(t - g), 32'(TO + 1));
      @(negedge clk);
      chk("to_idle", 32'(mem_req), 32'd0);
      chk("to_ok", 32'(data_ok), 32'd0);

      // Reset asserted while waiting for a response.
      @(negedge clk);
      data_addr = 32'h40;
      data_req = 1'b1;
      do_mem(32'h40, 32'h0, 4'h0, 0, 1'b0, 32'h0, g);
      @(negedge clk);
      rst = 1'b0;
      data_req = 1'b0;
      #1;
      chk("mr_req", 32'(mem_req), 32'd0);
      chk("mr_dok", 32'(data_ok), 32'd0);
      chk("mr_iok", 32'(inst_ok), 32'd0);
      chk("mr_drd", data_rdata, 32'd0);
      okc = ok_count;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata = 32'h12345678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      repeat (4) @(negedge clk);
      chk("mr_no_ok", 32'(ok_count), 32'(okc));
      chk("mr_idle", 32'(mem_req), 32'd0);

      // Arbitration resumes after the reset.
      inst_addr = 32'h4;
      inst_req = 1'b1;
      rc = cyc;
      push_exp(1'b0, 32'hCAFEF00D, 1'b1, 1'b0);
      do_mem(32'h4, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, g);
      wait_ok(t);
      inst_req = 1'b0;
      chk("post_lat", 32'(t - rc), 32'd3);

      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before a bus error (1..255).
REQ-004 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports inst_req/inst_addr, input, 1/ADDR_W, the fetch read request.
REQ-007 SHALL have ports inst_rdata/inst_ok, output, DATA_W/1, the fetch read data and completion pulse.
REQ-008 SHALL have ports data_req/data_addr/data_wdata/data_wen, input, 1/ADDR_W/DATA_W/4, the MEM-stage request; data_wen equal to 0 means read, any other value means write with byte enables.
REQ-009 SHALL have ports data_rdata/data_ok, output, DATA_W/1, the MEM-stage read data and completion pulse.
REQ-010 SHALL have ports mem_req/mem_addr/mem_wdata/mem_wen, output, 1/ADDR_W/DATA_W/4, the shared memory address phase.
REQ-011 SHALL have ports mem_gnt/mem_rvalid/mem_rdata, input, 1/1/DATA_W, the memory address accept, response valid and read data.
REQ-012 SHALL have port bus_err, output, 1, a timeout flag pulsed together with the ok of the failed transaction.

Function
REQ-013 SHALL implement the FSM IDLE -> ADDR -> WAIT -> RESP -> IDLE, with a registered owner bit (0 = inst, 1 = data).
REQ-014 SHALL, in IDLE, grant according to these rules:
- only one requester active: that requester wins;
- both requesters active: the requester not served last wins (round-robin);
- neither active: remain in IDLE.
REQ-015 SHALL, on a grant, latch the winner's addr, wdata and wen (0 for inst) into registers and enter ADDR on the next cycle.
REQ-016 SHALL hold mem_req=1 and the latched address, data and enables constant throughout ADDR, and drive mem_req=0 in every other state.
REQ-017 SHALL move from ADDR to WAIT on the clock edge where mem_req and mem_gnt are both 1, and stay in ADDR indefinitely otherwise.
REQ-018 SHALL, in WAIT, move to RESP on mem_rvalid=1, capturing mem_rdata (writes also return mem_rvalid as the acknowledge; the captured data is then don't-care).
REQ-019 SHALL treat WAIT timeouts as follows:
- a wait counter clears on entry to WAIT and increments each WAIT cycle;
- when it reaches TIMEOUT without mem_rvalid, the FSM moves to RESP with captured data 0 and sets an error flag.
REQ-020 SHALL, in RESP, assert exactly one of inst_ok or data_ok for exactly one cycle according to owner, drive bus_err equal to the error flag, and record owner as last-served.
REQ-021 SHALL hold inst_rdata and data_rdata as registered outputs that keep their value until the next completion for the same requester.
REQ-022 SHALL ignore both requests during ADDR, WAIT and RESP; requesters hold req and their payload stable until their ok, and present a new request or deassert in the cycle after ok.
REQ-023 SHALL ignore mem_gnt outside ADDR and mem_rvalid outside WAIT.
REQ-024 SHALL give a minimum req-to-ok latency of 3 cycles (gnt and rvalid each returned in the cycle they are first possible) and a maximum of 1 (IDLE) + ADDR stall + TIMEOUT + 1 cycles.
REQ-025 SHALL have no combinational path from any input to any output.

Reset
REQ-026 SHALL, while rst=0, immediately and asynchronously force state IDLE, mem_req=0, mem_addr/mem_wdata/mem_wen=0, inst_ok=data_ok=bus_err=0, inst_rdata=data_rdata=0, wait counter 0, error flag 0 and last-served=inst.
REQ-027 SHALL, on reset assertion mid-transaction, abandon the transaction without issuing any ok, and SHALL begin arbitrating on the first rising clk edge after rst returns to 1.

Verification
REQ-028 SHALL cover an inst read: inst_req, addr 0xBFC00000, mem_gnt immediate, mem_rvalid rdata 0x24080001 next cycle -> inst_ok on cycle 3, inst_rdata=0x24080001, bus_err=0.
REQ-029 SHALL cover simultaneous requests after reset: both req in the same cycle -> data granted first, inst second; with both held continuously, grants alternate data, inst, data, inst.
REQ-030 SHALL cover a data write: data_wen=0b0011, addr 0x10, wdata 0xDEADBEEF, mem_gnt delayed 4 cycles -> mem_addr, mem_wdata and mem_wen stable for all 5 ADDR cycles, then one data_ok.
REQ-031 SHALL cover a timeout with TIMEOUT=8: no mem_rvalid -> data_ok together with bus_err=1 exactly 8 WAIT cycles after grant, data_rdata=0, FSM back in IDLE.
REQ-032 SHALL cover reset mid-WAIT: rst pulled low in WAIT -> mem_req=0 and ok=0 at once; no ok after release; a stale mem_rvalid in IDLE produces no ok.
